// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, FSM encoding and clog2 helper for the read-side packer
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Smallest r with (1 << r) >= value; used for lane-counter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pack_out_slot.sv
// rtl/pack_out_slot.sv - registered valid/ready output slice for packed beats
module pack_out_slot
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH*RATIO-1:0] load_data,
  input  logic [RATIO-1:0]       load_keep,
  input  logic                   load_last,
  output logic                   slot_free,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last
);

  logic                   valid_q;
  logic [WIDTH*RATIO-1:0] data_q;
  logic [RATIO-1:0]       keep_q;
  logic                   last_q;

  // The slot may take a new beat when empty or when its current beat leaves this cycle.
  assign slot_free = ~valid_q | out_ready;

  // Load a new beat when asked (caller guarantees slot_free); otherwise drop valid on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      keep_q  <= load_keep;
      last_q  <= load_last;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs RATIO of them into one wide beat, with flush
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int RATIO = 4
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last,
  output logic                   flush_busy
);

  localparam int             CW        = clog2(RATIO);
  localparam logic [CW-1:0]  LAST_LANE = CW'(RATIO - 1);

  // Only RATIO-1 lanes are stored; the final lane comes straight from the FIFO head.
  logic [RATIO-2:0][WIDTH-1:0] acc_q;
  logic [CW-1:0]               cnt_q;
  flush_state_e                state_q;

  logic                        flush_pend;
  logic                        slot_free;
  logic                        pop;
  logic                        full_load;
  logic                        flush_load;
  logic                        slot_load;
  logic [RATIO-1:0][WIDTH-1:0] load_lanes;
  logic [RATIO-1:0]            load_keep;

  assign flush_pend = (state_q == FLUSH);
  assign flush_busy = flush_pend;

  // The last lane can only be popped if the slot can take the completed beat in the same edge.
  assign pop        = ~rst & ~fifo_empty & ~flush_pend & ((cnt_q != LAST_LANE) | slot_free);
  assign fifo_rd_en = pop;

  assign full_load  = pop & (cnt_q == LAST_LANE);
  assign flush_load = flush_pend & (cnt_q != '0) & slot_free;
  assign slot_load  = full_load | flush_load;

  // Assemble the beat to load: full beat uses every lane, flush uses lanes below cnt and zeroes the rest.
  always_comb begin
    load_lanes = '0;
    load_keep  = '0;
    if (full_load) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        load_lanes[i] = acc_q[i];
      end
      load_lanes[RATIO-1] = fifo_rd_data;
      load_keep           = '1;
    end else begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (i < int'(cnt_q)) begin
          load_lanes[i] = acc_q[i];
          load_keep[i]  = 1'b1;
        end
      end
    end
  end

  // Accumulate popped words into lanes; cnt returns to zero only when a beat is loaded.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (pop) begin
      if (cnt_q == LAST_LANE) begin
        cnt_q <= '0;
      end else begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (cnt_q == CW'(i)) begin
            acc_q[i] <= fifo_rd_data;
          end
        end
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (flush_load) begin
      cnt_q <= '0;
    end
  end

  // Flush FSM: freeze intake, emit the partial beat once the slot is free, repeated flushes absorbed.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if ((cnt_q == '0) || slot_free) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pack_out_slot #(
    .WIDTH (WIDTH),
    .RATIO (RATIO)
  ) u_slot (
    .clk       (rd_clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (load_lanes),
    .load_keep (load_keep),
    .load_last (flush_load),
    .slot_free (slot_free),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard bench for the FIFO read-side packer
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        flush_busy;

  beat_t       sb[$];
  logic [7:0]  fq[$];
  logic [7:0]  m_lane[4];
  int          m_cnt = 0;
  int          nvec = 0;
  int          nerr = 0;
  int          pops = 0;
  int          busy_cycles = 0;
  logic        pop_en;

  fifo_rd_packer #(
    .WIDTH (WIDTH),
    .RATIO (RATIO)
  ) dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .flush_busy   (flush_busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    if (fq.size() > 0) fifo_rd_data = fq[0];
    else fifo_rd_data = 8'h00;
  endtask

  // Push a word into the FIFO model and into the packing model.
  task automatic push(input logic [7:0] w);
    beat_t b;
    fq.push_back(w);
    refresh();
    m_lane[m_cnt] = w;
    m_cnt++;
    if (m_cnt == RATIO) begin
      b.data = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
      b.keep = 4'hF;
      b.last = 1'b0;
      sb.push_back(b);
      m_cnt = 0;
    end
  endtask

  task automatic model_flush();
    beat_t b;
    if (m_cnt > 0) begin
      b.data = 32'h0;
      b.keep = 4'h0;
      b.last = 1'b1;
      for (int i = 0; i < m_cnt; i++) begin
        b.data[i*8 +: 8] = m_lane[i];
        b.keep[i] = 1'b1;
      end
      sb.push_back(b);
      m_cnt = 0;
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge rd_clk);
      #2;
    end
  endtask

  task automatic wait_sb(input string tag, input int max_cycles);
    for (int k = 0; k < max_cycles && sb.size() != 0; k++) step();
    chk(tag, sb.size(), 0);
  endtask

  // FIFO model: the pop decision is taken at the edge, the head advances just after it.
  always @(posedge rd_clk) begin
    pop_en = fifo_rd_en;
    #1;
    if (pop_en) begin
      chk("pop_when_nonempty", fq.size() > 0, 1);
      if (fq.size() > 0) void'(fq.pop_front());
      pops++;
      refresh();
    end
  end

  // Output monitor: compares presented beats against the scoreboard head.
  always @(negedge rd_clk) begin
    if (!rst) begin
      if (flush_busy) begin
        busy_cycles++;
        chk("no_pop_in_flush", fifo_rd_en, 0);
      end
      if (sb.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else if (out_valid) begin
        chk("beat_data", out_data, sb[0].data);
        chk("beat_keep", out_keep, sb[0].keep);
        chk("beat_last", out_last, sb[0].last);
        chk("keep_nonzero", out_keep != 4'h0, 1);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    refresh();
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_last", out_last, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", flush_busy, 0);
    rst = 1'b0;
    step();

    // Basic pack
    pops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_sb("basic_drain", 40);
    step(2);
    chk("basic_pops", pops, 4);

    // Backpressure
    out_ready = 1'b0;
    pops = 0;
    for (int i = 1; i <= 8; i++) push(8'((i << 4) | i));
    step(20);
    chk("bp_pops_stall", pops, 7);
    chk("bp_fifo_left", fq.size(), 1);
    chk("bp_cnt", dut.cnt_q, 3);
    chk("bp_valid", out_valid, 1);
    chk("bp_rd_en", fifo_rd_en, 0);
    out_ready = 1'b1;
    wait_sb("bp_drain", 40);
    step(2);
    chk("bp_pops_total", pops, 8);
    chk("bp_fifo_empty", fq.size(), 0);

    // Partial flush
    pops = 0;
    push(8'hA1); push(8'hB2); push(8'hC3);
    step(6);
    chk("pf_pops", pops, 3);
    busy_cycles = 0;
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    wait_sb("pf_drain", 20);
    step(2);
    chk("pf_busy_seen", busy_cycles >= 1, 1);
    chk("pf_busy_clear", flush_busy, 0);
    chk("pf_pops_after", pops, 3);

    // Flush on the same edge as the completing pop
    pops = 0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    step(3);
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    chk("coll_busy_set", flush_busy, 1);
    step();
    chk("coll_busy_clear", flush_busy, 0);
    wait_sb("coll_drain", 20);
    step(3);
    chk("coll_pops", pops, 4);

    // Flush with nothing accumulated
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    chk("ef_busy_set", flush_busy, 1);
    step();
    chk("ef_busy_clear", flush_busy, 0);
    step(3);
    chk("ef_no_valid", out_valid, 0);

    // Asynchronous reset mid-beat
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    step(10);
    chk("ar_valid_before", out_valid, 1);
    chk("ar_cnt_before", dut.cnt_q, 2);
    push(8'h07);
    #1;
    chk("ar_rd_en_before", fifo_rd_en, 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_cnt", dut.cnt_q, 0);
    chk("ar_rd_en", fifo_rd_en, 0);
    chk("ar_keep", out_keep, 0);
    sb.delete();
    fq.delete();
    refresh();
    m_cnt = 0;
    step(2);
    rst = 1'b0;
    out_ready = 1'b1;
    pops = 0;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    wait_sb("ar_drain", 40);
    step(2);
    chk("ar_pops", pops, 4);

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
